sprite_motion_ctrl: RTL and testbench

//  Per-frame motion sequencer for a block sprite (pong puck). Drives the sprite's
//  top-left position (o_x,o_y) to the sprite renderer, updates it once per frame

---
 rtl/pong_pkg.sv | 7 +
 rtl/sprite_motion_ctrl_if.sv | 19 +
 rtl/bounce_axis.sv | 30 +++
 rtl/sprite_motion_ctrl.sv | 69 ++++++
 tb/tb_sprite_motion_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry and motion types for the puck sequencer.
package pong_pkg;
  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} motion_state_t;
  typedef enum logic {POS = 1'b0, NEG = 1'b1} dir_t;
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// sprite_motion_ctrl_if: video timing, control and sprite position signals of the puck sequencer.
interface sprite_motion_ctrl_if #(parameter int SPEED_W = 4);
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic start;
  logic pause;
  logic [SPEED_W-1:0] dx_mag;
  logic [SPEED_W-1:0] dy_mag;
  logic [10:0] x;
  logic [9:0] y;
  logic [1:0] state;
  logic hit_x;
  logic hit_y;
  logic frame_tick;
  modport master(output hcount, vcount, start, pause, dx_mag, dy_mag,
                 input x, y, state, hit_x, hit_y, frame_tick);
  modport slave(input hcount, vcount, start, pause, dx_mag, dy_mag,
                output x, y, state, hit_x, hit_y, frame_tick);
endinterface

// File: rtl/bounce_axis.sv
// bounce_axis: one-axis step with wall reflection; the compare runs one bit wider so
// neither the add nor the subtract can wrap.
module bounce_axis
  import pong_pkg::*;
#(
  parameter int LIMIT   = 1152,
  parameter int POS_W   = 11,
  parameter int SPEED_W = 4
) (
  input  logic [POS_W-1:0]   pos,
  input  dir_t               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic               step_en,
  output logic [POS_W-1:0]   nxt_pos,
  output dir_t               nxt_dir,
  output logic               hit
);
  logic [POS_W:0] spd, sum;
  logic over, under;
  always_comb begin
    spd     = (POS_W+1)'(speed);
    sum     = {1'b0, pos} + spd;
    over    = dir == POS && sum > (POS_W+1)'(LIMIT);
    under   = dir == NEG && {1'b0, pos} < spd;
    hit     = step_en && (over || under);
    nxt_pos = !step_en ? pos : over ? POS_W'(LIMIT) : under ? '0 :
              dir == POS ? sum[POS_W-1:0] : pos - spd[POS_W-1:0];
    nxt_dir = !step_en ? dir : over ? NEG : under ? POS : dir;
  end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame puck position sequencer; steps once per frame in
// vertical blanking, the cycle after the registered frame tick.
module sprite_motion_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W = pong_pkg::SCREEN_W,
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 128,
  parameter int START_X  = 576,
  parameter int START_Y  = 296,
  parameter int SPEED_W  = 4
) (
  input logic clk,
  input logic rst_n,
  sprite_motion_ctrl_if.slave bus
);
  motion_state_t state, state_n;
  dir_t dir_x, dir_y, ndir_x, ndir_y;
  logic [SPEED_W-1:0] vx, vy;
  logic [10:0] pos_x, npos_x;
  logic [9:0] pos_y, npos_y;
  logic frame_tick, hit_x, hit_y, hx, hy, step_en, serve, tick_c;
  always_comb begin
    tick_c  = bus.hcount == 11'd0 && bus.vcount == 10'(SCREEN_H);
    serve   = state == IDLE && bus.start;
    step_en = state == RUN && frame_tick && !bus.pause;
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : (bus.pause ? PAUSE : RUN);
  end
  bounce_axis #(.LIMIT(SCREEN_W - WIDTH), .POS_W(11), .SPEED_W(SPEED_W)) u_x (
    .pos(pos_x), .dir(dir_x), .speed(vx), .step_en(step_en),
    .nxt_pos(npos_x), .nxt_dir(ndir_x), .hit(hx)
  );
  bounce_axis #(.LIMIT(SCREEN_H - HEIGHT), .POS_W(10), .SPEED_W(SPEED_W)) u_y (
    .pos(pos_y), .dir(dir_y), .speed(vy), .step_en(step_en),
    .nxt_pos(npos_y), .nxt_dir(ndir_y), .hit(hy)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_x      <= 11'(START_X);
      pos_y      <= 10'(START_Y);
      dir_x      <= POS;
      dir_y      <= POS;
      vx         <= '0;
      vy         <= '0;
      frame_tick <= 1'b0;
      hit_x      <= 1'b0;
      hit_y      <= 1'b0;
    end else begin
      state      <= state_n;
      pos_x      <= npos_x;
      pos_y      <= npos_y;
      dir_x      <= serve ? POS : ndir_x;
      dir_y      <= serve ? POS : ndir_y;
      vx         <= serve ? bus.dx_mag : vx;
      vy         <= serve ? bus.dy_mag : vy;
      frame_tick <= tick_c;
      hit_x      <= hx;
      hit_y      <= hy;
    end
  end
  assign bus.x          = pos_x;
  assign bus.y          = pos_y;
  assign bus.state      = state;
  assign bus.hit_x      = hit_x;
  assign bus.hit_y      = hit_y;
  assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: randomized frames with pause/start/reset, checked every
// cycle against a frame-level model of the puck's motion.
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int mx, my, mdx, mdy, mvx, mvy, mst;
  bit mft, mhx, mhy;
  sprite_motion_ctrl_if #(.SPEED_W(4)) bus ();
  sprite_motion_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("x", 32'(bus.x), mx);
    check("y", 32'(bus.y), my);
    check("state", 32'(bus.state), mst);
    check("hit_x", 32'(bus.hit_x), 32'(mhx));
    check("hit_y", 32'(bus.hit_y), 32'(mhy));
    check("frame_tick", 32'(bus.frame_tick), 32'(mft));
  endtask

  task automatic model_reset();
    mx = 576; my = 296; mdx = 1; mdy = 1; mvx = 0; mvy = 0;
    mst = 0; mft = 0; mhx = 0; mhy = 0;
  endtask

  // One frame's move along an axis of the playfield [0, lim].
  task automatic step(inout int p, inout int d, input int v, input int lim, output bit h);
    h = 0;
    if (d > 0) begin
      if (p + v > lim) begin p = lim; d = -1; h = 1; end
      else p = p + v;
    end else begin
      if (p < v) begin p = 0; d = 1; h = 1; end
      else p = p - v;
    end
  endtask

  task automatic model_edge();
    int nst;
    nst = mst; mhx = 0; mhy = 0;
    if (mst == 0) begin
      if (bus.start) begin
        mvx = int'(bus.dx_mag); mvy = int'(bus.dy_mag); mdx = 1; mdy = 1; nst = 1;
      end
    end else if (mst == 1) begin
      if (bus.pause) nst = 2;
      else if (mft) begin
        step(mx, mdx, mvx, 1280 - 128, mhx);
        step(my, mdy, mvy, 720 - 128, mhy);
      end
    end else if (!bus.pause) nst = 1;
    mst = nst;
    mft = bus.hcount == 0 && bus.vcount == 720;
  endtask

  task automatic cycle(input bit tick);
    if (tick) begin
      bus.hcount = 11'd0; bus.vcount = 10'd720;
    end else if ($urandom_range(0, 1) == 0) begin
      bus.hcount = 11'd0; bus.vcount = 10'($urandom_range(0, 719));
    end else begin
      bus.hcount = 11'($urandom_range(1, 2047)); bus.vcount = 10'd720;
    end
    @(posedge clk);
    if (rst_n) model_edge();
    #1 compare_all();
  endtask

  task automatic frame();
    cycle(1'b1);
    repeat (3) cycle(1'b0);
  endtask

  // Reset asserted between clock edges must clear the outputs before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (2) cycle(1'b0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    bus.hcount = '0; bus.vcount = '0; bus.start = 0; bus.pause = 0;
    bus.dx_mag = '0; bus.dy_mag = '0;
    model_reset();
    repeat (2) cycle(1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      bus.pause = 1'($urandom_range(0, 1));
      frame();
    end
    bus.pause = 0; bus.dx_mag = 4'd4; bus.dy_mag = 4'd2; bus.start = 1;
    cycle(1'b0);
    bus.start = 0;
    repeat (3) frame();
    check("serve_x", 32'(bus.x), 588);
    check("serve_y", 32'(bus.y), 302);
    for (int f = 0; f < 200; f++) frame();
    for (int s = 0; s < 6; s++) begin
      async_reset();
      bus.dx_mag = (s == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.dy_mag = (s == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      bus.start = 1; bus.pause = 1;
      cycle(1'b0);
      for (int f = 0; f < 300; f++) begin
        bus.start = ($urandom_range(0, 7) == 0);
        bus.pause = ($urandom_range(0, 9) == 0);
        bus.dx_mag = 4'($urandom_range(0, 15));
        bus.dy_mag = 4'($urandom_range(0, 15));
        frame();
      end
      bus.pause = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
